if_stage: RTL
=============

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the ID/EX register.
//  Owns the fetch PC and drives the instruction-memory read handshake.
//  Buffers up to BUF_DEPTH fetched words so that imem latency and downstream stalls decouple.
//  Presents pc/pc+4/instruction/valid to the decode stage and obeys the same busywait/branch_jump_signal.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch PC loaded on reset
//  BUF_DEPTH  2              fetch buffer entries (power of 2, >=2); each entry = {pc, instr}
//  NOP_INSTR  32'h0000_0013  instruction driven with valid_out=0 (addi x0,x0,0)
// PORTS
//  clk                 in   1   clock; all state updates on posedge
//  reset               in   1   synchronous, active-low reset
//  busywait            in   1   downstream stall (data memory); 1 = hold IF/ID outputs
//  branch_jump_signal  in   1   taken branch/jump from EX; flush and redirect
//  branch_jump_addr    in   32  redirect target, sampled when branch_jump_signal=1
//  i_mem_read          out  1   instruction read request
//  i_mem_address       out  32  word-aligned fetch address (= fetch_pc)
//  i_mem_readdata      in   32  instruction word, valid when read=1 and i_mem_busywait=0
//  i_mem_busywait      in   1   imem busy; 1 = request not yet complete
//  instruction_out     out  32  IF/ID instruction
//  pc_out              out  32  IF/ID pc of instruction_out
//  pc_4_out            out  32  IF/ID pc_out + 4
//  valid_out           out  1   1 = instruction_out is real, 0 = bubble
// BEHAVIOUR
//  Reset (reset=0 at edge, highest priority): fetch_pc<=RESET_PC, buffer count<=0, state<=REQ,
//   instruction_out<=NOP_INSTR, pc_out<=0, pc_4_out<=0, valid_out<=0. i_mem_read low the cycle after.
//  FSM: REQ (normal), DROP (discard one in-flight response after a flush).
//   i_mem_read = (REQ && count<BUF_DEPTH) || DROP; i_mem_address = fetch_pc.
//   Response = edge with i_mem_read=1 && i_mem_busywait=0.
//   REQ response: push {fetch_pc, i_mem_readdata}; fetch_pc<=fetch_pc+4 (mod 2^32, wraps).
//   DROP response: data discarded, state<=REQ; fetch_pc unchanged (already redirected).
//  Pop: when busywait=0 and count>0, head loads IF/ID regs, valid_out<=1, pc_4_out<=head.pc+4.
//   busywait=0 and count=0 (no bypass): valid_out<=0, instruction_out<=NOP_INSTR, pc regs hold.
//   busywait=1: all IF/ID outputs hold; buffer may still fill up to BUF_DEPTH.
//  Push and pop same edge: count unchanged; FIFO order preserved; full buffer deasserts i_mem_read.
//  Flush (branch_jump_signal=1, overrides busywait): fetch_pc<=branch_jump_addr, count<=0,
//   valid_out<=0, instruction_out<=NOP_INSTR. If REQ with i_mem_read=1 and i_mem_busywait=1:
//   state<=DROP (request held until it completes, never abandoned). If response lands on the
//   flush edge: discarded, state stays REQ.
//  Flush during DROP: new target loaded, stays DROP.
//  Latency (no bypass): response at edge N -> on outputs after edge N+1 (if busywait=0).
//  fetch_pc[1:0] forced 0; misaligned branch_jump_addr low bits ignored.
// CONFIGURATION
//  IF_BYPASS_EN defined: response with count=0, busywait=0, no flush loads IF/ID regs directly
//   at edge N (latency 1, not pushed). Undefined: always through buffer, latency 2.
// TESTING
//  1 reset=0 two cycles, RESET_PC=32'h100 -> valid_out=0, instr=32'h13, next fetch addr 32'h100.
//  2 zero-wait imem returning addr-derived words -> pc_out 0x100,0x104,0x108 on consecutive
//    cycles, pc_4_out=pc_out+4, no gaps after first (latency 2, 1 with IF_BYPASS_EN).
//  3 busywait=1 for 5 cycles -> outputs frozen, count reaches 2, i_mem_read drops;
//    release -> 0x108,0x10C,0x110 in order, none lost or duplicated.
//  4 imem 3-cycle busy; flush to 0x200 at busy cycle 1 -> stale word discarded (DROP),
//    i_mem_read held until done, next valid pc_out=0x200.
//  5 flush and busywait=1 same edge -> valid_out=0 next cycle, buffer empty, fetch addr=target.
//  6 fetch_pc=32'hFFFF_FFFC response -> fetch_pc wraps to 0, pc_4_out=0.

Source files
------------

// File: rtl/if_stage.sv
// if_stage -- instruction fetch stage with IF/ID pipeline register.
//
// Owns the fetch PC and runs the instruction-memory read handshake. Fetched
// words go into a small FIFO, so imem latency and downstream stalls do not
// have to line up. The head of that FIFO is presented to decode.
//
// Optional feature macro: IF_BYPASS_EN
//   defined   : a response that arrives while the FIFO is empty, with no
//               stall and no flush, loads IF/ID directly (1-cycle latency).
//   undefined : every word passes through the FIFO (2-cycle latency).
//
// Ports
//   clk                 in   clock, all state on posedge
//   reset               in   synchronous, active-low
//   busywait            in   downstream stall, 1 = hold IF/ID outputs
//   branch_jump_signal  in   taken branch/jump: flush and redirect
//   branch_jump_addr    in   redirect target (low two bits ignored)
//   i_mem_read          out  imem read request
//   i_mem_address       out  word-aligned fetch address
//   i_mem_readdata      in   imem data, valid when read=1 and i_mem_busywait=0
//   i_mem_busywait      in   imem busy, 1 = request not yet complete
//   instruction_out     out  IF/ID instruction
//   pc_out              out  IF/ID pc of instruction_out
//   pc_4_out            out  IF/ID pc_out + 4
//   valid_out           out  1 = real instruction, 0 = bubble
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busywait,
  input  logic        branch_jump_signal,
  input  logic [31:0] branch_jump_addr,
  output logic        i_mem_read,
  output logic [31:0] i_mem_address,
  input  logic [31:0] i_mem_readdata,
  input  logic        i_mem_busywait,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_4_out,
  output logic        valid_out
);

  localparam int         PW     = $clog2(BUF_DEPTH);
  localparam logic [PW:0] FULL  = (PW+1)'(BUF_DEPTH);
  localparam logic [0:0] S_REQ  = 1'b0;
  localparam logic [0:0] S_DROP = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t [BUF_DEPTH-1:0] fifo;
  entry_t                 head;

  logic [0:0]    state;
  logic          run;       // low for one cycle after reset: no request yet
  logic [31:0]   fetch_pc;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          resp, req_resp, bypass, push, pop;

  // DROP keeps the request up until the stale response has been consumed.
  assign i_mem_read    = run && ((state == S_REQ && count < FULL) || state == S_DROP);
  assign i_mem_address = fetch_pc;

  assign resp     = i_mem_read && !i_mem_busywait;
  assign req_resp = resp && (state == S_REQ);
`ifdef IF_BYPASS_EN
  assign bypass   = req_resp && (count == '0) && !busywait && !branch_jump_signal;
`else
  assign bypass   = 1'b0;
`endif
  assign push     = req_resp && !branch_jump_signal && !bypass;
  assign pop      = !busywait && (count != '0) && !branch_jump_signal;
  assign head     = fifo[rd_ptr];

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{pc: fetch_pc, instr: i_mem_readdata};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= S_REQ;
      run             <= 1'b0;
      fetch_pc        <= RESET_PC & 32'hFFFF_FFFC;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      instruction_out <= NOP_INSTR;
      pc_out          <= '0;
      pc_4_out        <= '0;
      valid_out       <= 1'b0;
    end else begin
      run <= 1'b1;
      if (branch_jump_signal) begin
        fetch_pc        <= branch_jump_addr & 32'hFFFF_FFFC;
        rd_ptr          <= '0;
        wr_ptr          <= '0;
        count           <= '0;
        valid_out       <= 1'b0;
        instruction_out <= NOP_INSTR;
        // An outstanding imem request cannot be cancelled; its answer must be
        // swallowed later. A response landing on this edge is simply ignored.
        if (state == S_REQ && i_mem_read && i_mem_busywait) state <= S_DROP;
      end else begin
        if (req_resp) fetch_pc <= fetch_pc + 32'd4;
        if (resp && state == S_DROP) state <= S_REQ;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;

        if (!busywait) begin
          if (pop) begin
            instruction_out <= head.instr;
            pc_out          <= head.pc;
            pc_4_out        <= head.pc + 32'd4;
            valid_out       <= 1'b1;
          end else if (bypass) begin
            instruction_out <= i_mem_readdata;
            pc_out          <= fetch_pc;
            pc_4_out        <= fetch_pc + 32'd4;
            valid_out       <= 1'b1;
          end else begin
            // bubble: pc registers keep their last value
            instruction_out <= NOP_INSTR;
            valid_out       <= 1'b0;
          end
        end
      end
    end
  end

endmodule
